// File: rtl/piccolo_pkg.sv
// ============================================================
// piccolo_pkg : shared Piccolo-128 constants, S-box, GF(2^4) mixing, key constants
// Rev 1.0
// ============================================================
`default_nettype none

package piccolo_pkg;

  localparam int NR   = 31;
  localparam int RK_N = 62;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'he;  4'h1: return 4'h4;  4'h2: return 4'hb;  4'h3: return 4'h2;
      4'h4: return 4'h3;  4'h5: return 4'h8;  4'h6: return 4'h0;  4'h7: return 4'h9;
      4'h8: return 4'h1;  4'h9: return 4'ha;  4'ha: return 4'h7;  4'hb: return 4'hf;
      4'hc: return 4'h6;  4'hd: return 4'hc;  4'he: return 4'h5;  default: return 4'hd;
    endcase
  endfunction

  // Multiply by x modulo x^4+x+1: the dropped x^4 folds back as x+1.
  function automatic logic [3:0] mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] mul3(input logic [3:0] a);
    return mul2(a) ^ a;
  endfunction

  function automatic logic [15:0] mix_m(input logic [15:0] a);
    logic [3:0] a0, a1, a2, a3;
    a0 = a[15:12]; a1 = a[11:8]; a2 = a[7:4]; a3 = a[3:0];
    return {mul2(a0) ^ mul3(a1) ^ a2       ^ a3,
            a0       ^ mul2(a1) ^ mul3(a2) ^ a3,
            a0       ^ a1       ^ mul2(a2) ^ mul3(a3),
            mul3(a0) ^ a1       ^ a2       ^ mul2(a3)};
  endfunction

  function automatic logic [31:0] con128(input logic [4:0] i);
    logic [4:0] c;
    c = i + 5'd1;
    return {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h6547a98b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piccolo_round.sv
// ============================================================
// piccolo_round : one Piccolo round (F, key XOR, RP with last-round bypass)
// Rev 1.0
// ============================================================
`default_nettype none

module piccolo_round
  import piccolo_pkg::*;
(
  input  logic [63:0] x,
  input  logic [15:0] rk0,
  input  logic [15:0] rk1,
  input  logic        last_round,
  output logic [63:0] y
);

  function automatic logic [15:0] f_func(input logic [15:0] v);
    logic [15:0] a, m;
    a = {sbox(v[15:12]), sbox(v[11:8]), sbox(v[7:4]), sbox(v[3:0])};
    m = mix_m(a);
    return {sbox(m[15:12]), sbox(m[11:8]), sbox(m[7:4]), sbox(m[3:0])};
  endfunction

  logic [63:0] w_mix;

  assign w_mix = {x[63:48], x[47:32] ^ f_func(x[63:48]) ^ rk0,
                  x[31:16], x[15:0]  ^ f_func(x[31:16]) ^ rk1};

  // RP byte order (b0..b7) -> (b2,b7,b4,b1,b6,b3,b0,b5)
  assign y = last_round ? w_mix :
             {w_mix[47:40], w_mix[7:0],   w_mix[31:24], w_mix[55:48],
              w_mix[15:8],  w_mix[39:32], w_mix[63:56], w_mix[23:16]};

endmodule

`default_nettype wire

// File: rtl/piccolo128_dec.sv
// ============================================================
// piccolo128_dec : iterative Piccolo-128 decryption, key expansion then 31 rounds
// Rev 1.0
// ============================================================
`default_nettype none

module piccolo128_dec
  import piccolo_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] keyin,
  input  logic [63:0]  ciphertext,
  output logic         busy,
  output logic         done,
  output logic [63:0]  plaintext
);

  localparam logic [4:0] c_last = 5'(NR - 1);

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cnt;
  logic [63:0]      r_x;
  logic [31:0]      r_wk_out;
  logic [0:7][15:0] w_kin, r_key, w_kp;
  logic [31:0]      r_ks [RK_N/2];
  logic             w_accept, w_kexp_en, w_dec_en, w_finish;
  logic [2:0]       w_ia, w_ib;
  logic [31:0]      w_rk_pair, w_ks_rd;
  logic [15:0]      w_rk0, w_rk1;
  logic [15:0]      w_wk0, w_wk1, w_wk2, w_wk3;
  logic [63:0]      w_rnd;

  assign w_kin = keyin;
  assign w_wk0 = {w_kin[0][15:8], w_kin[1][7:0]};
  assign w_wk1 = {w_kin[1][15:8], w_kin[0][7:0]};
  assign w_wk2 = {w_kin[4][15:8], w_kin[7][7:0]};
  assign w_wk3 = {w_kin[7][15:8], w_kin[4][7:0]};

  // Key words are permuted cumulatively whenever (2j+2) mod 8 == 0, i.e. j mod 4 == 3.
  assign w_kp = (r_cnt[1:0] == 2'd3) ?
                {r_key[2], r_key[1], r_key[6], r_key[7], r_key[0], r_key[3], r_key[4], r_key[5]} :
                r_key;
  assign w_ia      = {r_cnt[1:0] + 2'd1, 1'b0};
  assign w_ib      = {r_cnt[1:0] + 2'd1, 1'b1};
  assign w_rk_pair = {w_kp[w_ia], w_kp[w_ib]} ^ con128(r_cnt);

  // Entry 30-i holds {rk60-2i, rk61-2i}; odd rounds take the pair swapped.
  assign w_ks_rd = r_ks[c_last - r_cnt];
  assign w_rk0   = r_cnt[0] ? w_ks_rd[15:0]  : w_ks_rd[31:16];
  assign w_rk1   = r_cnt[0] ? w_ks_rd[31:16] : w_ks_rd[15:0];

  piccolo_round u_round (
    .x          (r_x),
    .rk0        (w_rk0),
    .rk1        (w_rk1),
    .last_round (r_cnt == c_last),
    .y          (w_rnd)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_kexp_en   = 1'b0;
    w_dec_en    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (start && !done) begin
        w_accept    = 1'b1;
        w_state_nxt = KEXP;
      end
      KEXP: begin
        w_kexp_en = 1'b1;
        if (r_cnt == c_last) w_state_nxt = DEC;
      end
      DEC: begin
        w_dec_en = 1'b1;
        if (r_cnt == c_last) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_kexp_en) r_ks[r_cnt] <= w_rk_pair;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      plaintext <= '0;
      r_cnt     <= '0;
    end else begin
      done <= w_finish;
      if (w_accept) begin
        busy     <= 1'b1;
        r_cnt    <= '0;
        r_x      <= ciphertext ^ {w_wk2, 16'h0, w_wk3, 16'h0};
        r_key    <= w_kin;
        r_wk_out <= {w_wk0, w_wk1};
      end else if (w_kexp_en) begin
        r_key <= w_kp;
        r_cnt <= (r_cnt == c_last) ? 5'd0 : r_cnt + 5'd1;
      end else if (w_dec_en) begin
        r_x   <= w_rnd;
        r_cnt <= r_cnt + 5'd1;
        if (w_finish) begin
          busy      <= 1'b0;
          r_cnt     <= '0;
          plaintext <= w_rnd ^ {r_wk_out[31:16], 16'h0, r_wk_out[15:0], 16'h0};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piccolo128_dec.sv
// ============================================================
// tb_piccolo128_dec : directed/round-trip bench for piccolo128_dec
// Rev 1.0
// ============================================================
`default_nettype none

module tb_piccolo128_dec;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] keyin;
  logic [63:0]  ciphertext;
  logic         busy;
  logic         done;
  logic [63:0]  plaintext;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piccolo128_dec dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .keyin      (keyin),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  // ---------------- reference model (encrypt forward, decrypt by true inversion)
  localparam logic [63:0] SBOX_T = 64'he4b238091a7f6c5d;
  localparam int MM [4][4] = '{'{2,3,1,1}, '{1,2,3,1}, '{1,1,2,3}, '{3,1,1,2}};
  localparam int RPT [8]   = '{2, 7, 4, 1, 6, 3, 0, 5};

  function automatic logic [3:0] m_sb(input logic [3:0] n);
    logic [63:0] t;
    t = SBOX_T;
    return t[63 - 4*int'(n) -: 4];
  endfunction

  function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, aa;
    p = 4'h0; aa = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [15:0] m_f(input logic [15:0] x);
    logic [3:0]  a [4];
    logic [3:0]  y;
    logic [15:0] r;
    for (int c = 0; c < 4; c++) a[c] = m_sb(x[15-4*c -: 4]);
    r = '0;
    for (int rr = 0; rr < 4; rr++) begin
      y = 4'h0;
      for (int c = 0; c < 4; c++) y = y ^ m_gmul(4'(MM[rr][c]), a[c]);
      r[15-4*rr -: 4] = m_sb(y);
    end
    return r;
  endfunction

  function automatic logic [63:0] m_rp(input logic [63:0] v, input bit inverse);
    logic [63:0] o;
    o = '0;
    for (int n = 0; n < 8; n++) begin
      if (!inverse) o[63-8*n -: 8]      = v[63-8*RPT[n] -: 8];
      else          o[63-8*RPT[n] -: 8] = v[63-8*n -: 8];
    end
    return o;
  endfunction

  function automatic logic [63:0] m_round(input logic [63:0] v, input logic [15:0] a, input logic [15:0] b);
    return {v[63:48], v[47:32] ^ m_f(v[63:48]) ^ a, v[31:16], v[15:0] ^ m_f(v[31:16]) ^ b};
  endfunction

  function automatic logic [63:0] model(input logic [127:0] key, input logic [63:0] blk, input bit decrypt);
    logic [15:0] k [8];
    logic [15:0] t [8];
    logic [15:0] rk [62];
    logic [15:0] wk0, wk1, wk2, wk3;
    logic [31:0] con;
    logic [4:0]  c;
    logic [63:0] v;
    for (int j = 0; j < 8; j++) k[j] = key[127-16*j -: 16];
    wk0 = {k[0][15:8], k[1][7:0]}; wk1 = {k[1][15:8], k[0][7:0]};
    wk2 = {k[4][15:8], k[7][7:0]}; wk3 = {k[7][15:8], k[4][7:0]};
    for (int i = 0; i < 31; i++) begin
      if ((2*i + 2) % 8 == 0) begin
        t = k;
        k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
        k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
      end
      c   = 5'(i + 1);
      con = {c, 5'd0, c, 2'b00, c, 5'd0, c} ^ 32'h6547a98b;
      rk[2*i]   = k[(2*i + 2) % 8] ^ con[31:16];
      rk[2*i+1] = k[(2*i + 3) % 8] ^ con[15:0];
    end
    v = blk;
    if (!decrypt) begin
      v = v ^ {wk0, 16'h0, wk1, 16'h0};
      for (int i = 0; i < 31; i++) begin
        v = m_round(v, rk[2*i], rk[2*i+1]);
        if (i != 30) v = m_rp(v, 1'b0);
      end
      v = v ^ {wk2, 16'h0, wk3, 16'h0};
    end else begin
      v = v ^ {wk2, 16'h0, wk3, 16'h0};
      for (int i = 30; i >= 0; i--) begin
        if (i != 30) v = m_rp(v, 1'b1);
        v = m_round(v, rk[2*i], rk[2*i+1]);
      end
      v = v ^ {wk0, 16'h0, wk1, 16'h0};
    end
    return v;
  endfunction

  // ---------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input logic [127:0] k, input logic [63:0] ct,
                           input logic [63:0] exp_pt, input string tag);
    int edges, busy_n;
    bit got;
    keyin = k; ciphertext = ct; start = 1'b1;
    edges = 0; busy_n = 0; got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      tick();
      edges++;
      start = 1'b0; keyin = ~k; ciphertext = ~ct;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"},   64'(edges), 64'd63);
    check({tag, "_busy_len"},  64'(busy_n), 64'd62);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_pt"}, plaintext, exp_pt);
    tick();
    check({tag, "_done_single"}, 64'(done), 64'd0);
    check({tag, "_pt_hold"}, plaintext, exp_pt);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence
  initial begin
    logic [127:0] k, kb;
    logic [63:0]  p, ct, exp_pt;
    int first_d, second_d, nd, nrise;
    bit prev_busy, prev_done, dbl;

    reset = 1'b1; start = 1'b0; keyin = '0; ciphertext = '0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pt",   plaintext, 64'd0);
    reset = 1'b0;
    tick();

    // Known answer through the reference encryption.
    k = 128'h00112233445566778899aabbccddeeff;
    p = 64'h0123456789abcdef;
    run_block(k, model(k, p, 1'b0), p, "kat");

    run_block('0, '0, model('0, '0, 1'b1), "zero_key");
    run_block('1, '1, model('1, '1, 1'b1), "ones_key");

    for (int n = 0; n < 200; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      run_block(k, model(k, p, 1'b0), p, $sformatf("rt%0d", n));
    end

    // start held high for 100 cycles, inputs garbled while busy.
    k  = 128'hfedcba98765432100123456789abcdef;
    p  = 64'h55aa33cc0ff0a5a5;
    ct = model(k, p, 1'b0);
    keyin = k; ciphertext = ct; start = 1'b1;
    first_d = 0; second_d = 0; nd = 0; nrise = 0;
    prev_busy = 1'b0; prev_done = 1'b0; dbl = 1'b0;
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (c == 100) start = 1'b0;
      if (c >= 2 && c <= 60) begin keyin = ~k; ciphertext = ~ct; end
      else begin keyin = k; ciphertext = ct; end
      if (done) begin
        nd++;
        if (first_d == 0) first_d = c; else second_d = c;
      end
      if (done && prev_done) dbl = 1'b1;
      if (busy && !prev_busy) nrise++;
      prev_busy = busy; prev_done = done;
    end
    check("hold_n_done",  64'(nd), 64'd2);
    check("hold_n_acc",   64'(nrise), 64'd2);
    check("hold_first",   64'(first_d), 64'd63);
    check("hold_period",  64'(second_d - first_d), 64'd64);
    check("hold_no_dbl",  64'(dbl), 64'd0);
    check("hold_pt",      plaintext, p);

    // Reset in the middle of the DEC phase.
    k = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    keyin = k; ciphertext = 64'h1122334455667788; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_pt",   plaintext, 64'd0);
    reset = 1'b0;
    kb = 128'h13579bdf2468ace0fdb97531eca86420;
    p  = 64'hdeadbeefcafef00d;
    run_block(kb, model(kb, p, 1'b0), p, "post_abort");

    // Back-to-back blocks, same ciphertext, different keys.
    ct = 64'h0123456789abcdef;
    exp_pt = model(k, ct, 1'b1);
    run_block(k, ct, exp_pt, "b2b_a");
    for (int c = 0; c < 3; c++) tick();
    check("b2b_a_idle_hold", plaintext, exp_pt);
    run_block(kb, ct, model(kb, ct, 1'b1), "b2b_b");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
